// File: rtl/kvs_lookup_responder.sv
// KVS lookup responder: direct-mapped hashed key table answering one request per cycle
// at a fixed three-cycle latency, with a clear sweep after every reset.
module kvs_lookup_responder #(
    parameter int KEY_SIZE   = 96,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    input  logic                in_valid,
    output logic                out_valid,
    output logic [3:0]          out_flag,
    output logic                init_done
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int NCHUNKS = (KEY_SIZE + ADDR_WIDTH - 1) / ADDR_WIDTH;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_NOP    = 2'b11
    } op_e;

    typedef struct packed {
        logic                valid;
        logic [KEY_SIZE-1:0] tag;
    } entry_t;

    function automatic logic [ADDR_WIDTH-1:0] fold_hash(input logic [KEY_SIZE-1:0] key);
        logic [NCHUNKS*ADDR_WIDTH-1:0] padded;
        logic [ADDR_WIDTH-1:0]         h;
        padded                 = '0;
        padded[KEY_SIZE-1:0]   = key;
        h                      = '0;
        for (int c = 0; c < NCHUNKS; c++) begin
            h ^= padded[c*ADDR_WIDTH +: ADDR_WIDTH];
        end
        return h;
    endfunction

    entry_t mem [DEPTH];

    logic [ADDR_WIDTH-1:0] init_idx_q, init_idx_d;
    logic                  init_done_q, init_done_d;
    logic                  s1_valid_q, s1_valid_d, s1_nr_q, s1_nr_d;
    logic                  s2_valid_q, s2_valid_d, s2_nr_q, s2_nr_d;
    op_e                   s1_op_q, s1_op_d, s2_op_q, s2_op_d;
    logic [KEY_SIZE-1:0]   s1_key_q, s1_key_d, s2_key_q, s2_key_d;
    logic [ADDR_WIDTH-1:0] s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
    entry_t                rd_entry_q;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [ADDR_WIDTH-1:0] fwd_idx_q, fwd_idx_d;
    entry_t                fwd_entry_q, fwd_entry_d;
    logic                  out_valid_q, out_valid_d;
    logic [3:0]            out_flag_q, out_flag_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    entry_t                mem_wdata;
    entry_t                cur;
    logic                  hit;

    logic unused_flag_bits;
    assign unused_flag_bits = ^in_flag[3:2];

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        s1_valid_d  = in_valid;
        s1_nr_d     = !init_done_q;
        s1_op_d     = op_e'(in_flag[1:0]);
        s1_key_d    = in_key;
        s1_idx_d    = fold_hash(in_key);
        s2_valid_d  = s1_valid_q;
        s2_nr_d     = s1_nr_q;
        s2_op_d     = s1_op_q;
        s2_key_d    = s1_key_q;
        s2_idx_d    = s1_idx_q;
        fwd_valid_d = fwd_valid_q;
        fwd_idx_d   = fwd_idx_q;
        fwd_entry_d = fwd_entry_q;
        out_valid_d = s2_valid_q;
        out_flag_d  = 4'b0000;
        mem_we      = 1'b0;
        mem_waddr   = s2_idx_q;
        mem_wdata   = '0;

        // The RAM read for S2 raced the previous cycle's write; the last write is replayed here.
        cur = (fwd_valid_q && fwd_idx_q == s2_idx_q) ? fwd_entry_q : rd_entry_q;
        hit = cur.valid && (cur.tag == s2_key_q);

        if (!init_done_q) begin
            mem_we     = 1'b1;
            mem_waddr  = init_idx_q;
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == ADDR_WIDTH'(DEPTH - 1)) init_done_d = 1'b1;
        end

        if (s2_valid_q) begin
            if (s2_nr_q) begin
                out_flag_d = 4'b1000;
            end else begin
                unique case (s2_op_q)
                    OP_LOOKUP: out_flag_d = {3'b001, hit};
                    OP_INSERT: begin
                        if (!cur.valid) begin
                            out_flag_d = 4'b0010;
                            mem_we     = 1'b1;
                            mem_wdata  = '{valid: 1'b1, tag: s2_key_q};
                        end else if (hit) begin
                            out_flag_d = 4'b0011;
                        end else begin
                            out_flag_d = 4'b0100;
                        end
                    end
                    OP_DELETE: begin
                        out_flag_d = {3'b001, hit};
                        if (hit) begin
                            mem_we    = 1'b1;
                            mem_wdata = '{valid: 1'b0, tag: cur.tag};
                        end
                    end
                    default: out_flag_d = 4'b0010;
                endcase
                if (mem_we) begin
                    fwd_valid_d = 1'b1;
                    fwd_idx_d   = s2_idx_q;
                    fwd_entry_d = mem_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_flag_q  <= 4'b0000;
        end else begin
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            fwd_valid_q <= fwd_valid_d;
            out_valid_q <= out_valid_d;
            out_flag_q  <= out_flag_d;
        end
    end

    // NOTE: payload registers and the table itself carry no reset; valid bits and the
    // clear sweep decide when their contents mean anything.
    always_ff @(posedge clk) begin
        s1_nr_q     <= s1_nr_d;
        s1_op_q     <= s1_op_d;
        s1_key_q    <= s1_key_d;
        s1_idx_q    <= s1_idx_d;
        s2_nr_q     <= s2_nr_d;
        s2_op_q     <= s2_op_d;
        s2_key_q    <= s2_key_d;
        s2_idx_q    <= s2_idx_d;
        fwd_idx_q   <= fwd_idx_d;
        fwd_entry_q <= fwd_entry_d;
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
        rd_entry_q  <= mem[s1_idx_q];
    end

    assign out_valid = out_valid_q;
    assign out_flag  = out_flag_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_kvs_lookup_responder.sv
// Randomised scoreboard bench for kvs_lookup_responder: a sequential table model predicts
// each response and its due cycle; a negedge monitor compares what the DUT presents.
module tb_kvs_lookup_responder;

    localparam int KS    = 96;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [KS-1:0] in_key = '0;
    logic [3:0]    in_flag = 4'b0000;
    logic          in_valid = 1'b0;
    logic          out_valid;
    logic [3:0]    out_flag;
    logic          init_done;

    kvs_lookup_responder #(.KEY_SIZE(KS), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_key    (in_key),
        .in_flag   (in_flag),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .out_flag  (out_flag),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [3:0] flag;
    } exp_t;

    exp_t          exp_q[$];
    bit            m_valid [DEPTH];
    logic [KS-1:0] m_tag   [DEPTH];
    int            cyc = 0;
    int            rst_cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [KS-1:0] pool [8];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, actual, expected);
        end
    endtask

    // Reference index: XOR of successive AW-bit slices of the key, LSB first.
    function automatic int ref_index(input logic [KS-1:0] key);
        logic [KS-1:0] k = key;
        int            idx = 0;
        for (int c = 0; c < KS; c += AW) begin
            idx ^= int'(k & KS'(DEPTH - 1));
            k = k >> AW;
        end
        return idx;
    endfunction

    function automatic logic [3:0] model_exec(input logic [1:0] op, input logic [KS-1:0] key,
                                              input bit ready);
        int idx;
        bit present, match;
        if (!ready) return 4'b1000;
        idx     = ref_index(key);
        present = m_valid[idx];
        match   = present && (m_tag[idx] == key);
        case (op)
            2'b00: return match ? 4'b0011 : 4'b0010;
            2'b01: begin
                if (!present) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = key;
                    return 4'b0010;
                end
                return match ? 4'b0011 : 4'b0100;
            end
            2'b10: begin
                if (match) begin
                    m_valid[idx] = 1'b0;
                    return 4'b0011;
                end
                return 4'b0010;
            end
            default: return 4'b0010;
        endcase
    endfunction

    // Cycle counter, reset tracking, and dropping of anything a reset cancels.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            rst_cyc = cyc;
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end
    end

    // Monitor: sample mid-cycle, compare against the scoreboard head.
    always @(negedge clk) begin
        if (cyc > 0) begin
            bit exp_v;
            check("init_done", {7'd0, init_done}, {7'd0, (cyc >= rst_cyc + DEPTH)});
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("out_valid", {7'd0, out_valid}, {7'd0, exp_v});
            if (exp_v) begin
                check("out_flag", {4'd0, out_flag}, {4'd0, exp_q[0].flag});
                void'(exp_q.pop_front());
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [KS-1:0] key);
        exp_t e;
        logic [1:0] junk;
        @(negedge clk);
        junk     = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
        in_key   = key;
        in_flag  = {junk, op};
        if (!rst) begin
            e.due  = cyc + 3;
            e.flag = model_exec(op, key, cyc >= rst_cyc + DEPTH);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_init();
        int budget = 2 * DEPTH;
        while (!(cyc >= rst_cyc + DEPTH + 2) && budget > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            budget--;
        end
    endtask

    initial begin
        int budget;
        // Reset, then idle through the whole clear sweep.
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        wait_init();
        idle(4);

        // Lookup of an absent key after init.
        issue(2'b00, KS'(5));
        idle(2);

        // Back-to-back insert/lookup/delete/lookup on one key.
        issue(2'b01, KS'('hA));
        issue(2'b00, KS'('hA));
        issue(2'b10, KS'('hA));
        issue(2'b00, KS'('hA));
        idle(2);

        // Two keys folding to index 1.
        issue(2'b01, KS'(1));
        issue(2'b01, KS'(1) << 10);
        issue(2'b00, KS'(1) << 10);
        issue(2'b00, KS'(1));
        idle(2);

        // Duplicate insert with a gap, delete of an absent key, nop.
        issue(2'b01, KS'('h77));
        idle(1);
        issue(2'b01, KS'('h77));
        issue(2'b10, KS'('h99));
        issue(2'b11, KS'('h1234));
        idle(3);

        // Random traffic over a small key pool with deliberate index sharing.
        for (int i = 0; i < 4; i++) begin
            pool[i]     = KS'($urandom_range(0, 31));
            pool[i + 4] = pool[i] << 10;
        end
        for (int i = 0; i < 400; i++) begin
            logic [KS-1:0] k;
            if ($urandom_range(0, 9) == 0) k = {$urandom, $urandom, $urandom};
            else k = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) idle(1);
            else issue(2'($urandom_range(0, 3)), k);
        end
        idle(4);

        // Reset with three requests in flight; the table must come back empty.
        issue(2'b01, KS'('h123));
        idle(4);
        issue(2'b00, KS'('h123));
        issue(2'b01, KS'('h55));
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_key   = KS'('h55);
        in_flag  = 4'b0000;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        issue(2'b00, KS'(5));
        idle(1);
        wait_init();
        issue(2'b00, KS'('h123));
        issue(2'b00, KS'(5));
        idle(1);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain_empty", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kvs_lookup_responder.md
Name: kvs_lookup_responder

Overview:
- Responder end of the KVS network interface. eth_top issues key/flag requests; this block answers each one with a result flag.
- Sits in the db_top clock domain and holds an on-chip, direct-mapped, hashed key table.
- The interface has no backpressure, so the block accepts one request every cycle and returns one response per request, in order, at fixed latency.
- Results equal those of strictly sequential execution of the requests.

Parameters:
- KEY_SIZE, 96, width of in_key in bits (5-tuple-derived flow key).
- ADDR_WIDTH, 10, log2 of table depth; the table has 2^ADDR_WIDTH entries of {valid, KEY_SIZE-bit tag}.

Ports:
- clk  input  1  the db_clk domain clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_key  input  KEY_SIZE  request key.
- in_flag  input  4  [1:0] opcode: 00 lookup, 01 insert, 10 delete, 11 nop. [3:2] ignored.
- in_valid  input  1  request present this cycle; no ready signal, always accepted.
- out_valid  output  1  one-cycle response strobe.
- out_flag  output  4  [0] hit, [1] ack, [2] collision, [3] not_ready.
- init_done  output  1  table clear sweep complete.

Behaviour:
- Reset: every output and pipeline valid bit is 0 on the cycle after rst is sampled high. A reset mid-operation drops all in-flight requests (no responses for them) and restarts the init sweep.
- Init sweep: starts in the first cycle with rst low. One entry per cycle, index 0 up to 2^ADDR_WIDTH-1, has its valid bit written to 0. init_done goes to 1 in the cycle after the last index is written (2^ADDR_WIDTH cycles after rst deasserts) and stays 1 until the next rst.
- A request accepted while init_done=0 gets a response with out_flag=4'b1000 and does not touch the table.
- Hash index: XOR fold of in_key into ADDR_WIDTH-bit chunks, starting at the LSB; the last chunk is zero-padded.
  - Example: key = 1 gives index 1; key = 1<<ADDR_WIDTH also gives index 1.
- Pipeline and latency:
  - Request sampled at cycle T with in_valid=1.
  - S1: registered key, opcode and index.
  - S2: synchronous RAM read.
  - S3: tag compare, writeback, response register.
  - out_valid=1 at cycle T+3 with that request's out_flag; out_valid=0 in every other cycle.
- Hit definition: hit=1 iff the entry at the index has valid=1 and tag==key, evaluated on the table state after all earlier requests.
- Opcode results (out_flag is {not_ready, collision, ack, hit}):
  - lookup: no write. Response {0,0,1,hit}.
  - insert, empty slot: write {1,key}. Response 4'b0010.
  - insert, same key present: no change. Response 4'b0011.
  - insert, slot holds a different valid key: no write. Response 4'b0100.
  - delete, hit: clear valid. Response 4'b0011.
  - delete, miss: no write. Response 4'b0010.
  - nop: no read dependence, no write. Response 4'b0010.
- Hazards: back-to-back or gap-1 requests to the same index see earlier writes. The RAM read-during-write race at S3 vs S2/S1 must be covered by forwarding the S3 write data (match on index) into the compare. There are no stalls and no dropped requests.
- The block never asserts more than one response per cycle and never reorders responses.

Test Plan:
1. Reset, then hold in_valid=0 -> init_done=0 for exactly 1024 cycles after rst falls, then init_done=1; out_valid stays 0 throughout.
2. Before init_done, lookup key=5 at cycle T -> out_valid=1 at T+3 with out_flag=4'b1000. After init, lookup key=5 -> 4'b0010.
3. Back-to-back cycles: insert 0xA, lookup 0xA, delete 0xA, lookup 0xA -> responses on four consecutive cycles: 4'b0010, 4'b0011, 4'b0011, 4'b0010 (exercises forwarding).
4. Collision:
   - insert key=1, then insert key=1<<10 (same index 1) -> 4'b0010, then 4'b0100.
   - lookup 1<<10 -> 4'b0010; lookup 1 -> 4'b0011.
5. Duplicate and miss cases: insert 0x77 twice with one idle cycle between -> 4'b0010, 4'b0011. Delete an absent key 0x99 -> 4'b0010. Nop -> 4'b0010.
6. Assert rst for 1 cycle while 3 requests are in flight -> no responses for them, init_done drops and re-asserts 1024 cycles later, and a previously inserted key now looks up as a miss (4'b0010).
